carry_skip_sub32_pipe: RTL and testbench

//   Pipelined 32-bit subtractor built from 4-bit carry-skip blocks. It is the subtract

---
 rtl/carry_skip_sub32_pipe_if.sv | 27 ++
 rtl/carry_skip_sub32_pipe.sv | 126 ++++++++++++
 tb/tb_carry_skip_sub32_pipe.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/carry_skip_sub32_pipe_if.sv
// Operand/result handshake bundle for the pipelined carry-skip subtractor.
// slave is the subtractor's view; master is the operand source / result consumer view.
interface carry_skip_sub32_pipe_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] diff;
  logic             borrow;
  logic             ovf;
  logic             zero;

  modport slave (
    input  in_valid, a, b, bin, out_ready,
    output in_ready, out_valid, diff, borrow, ovf, zero
  );

  modport master (
    output in_valid, a, b, bin, out_ready,
    input  in_ready, out_valid, diff, borrow, ovf, zero
  );
endinterface

// File: rtl/carry_skip_sub32_pipe.sv
// Two-stage pipelined subtractor (diff = a + ~b + ~bin) built from carry-skip blocks:
// low half in stage 1, high half plus flags in stage 2, valid/ready on both sides.

// One ripple block whose carry-out bypasses the ripple when every bit propagates.
module carry_skip_sub32_pipe_blk #(
  parameter int BLOCK = 4
) (
  input  logic [BLOCK-1:0] x,
  input  logic [BLOCK-1:0] y,
  input  logic             cin,
  output logic [BLOCK-1:0] s,
  output logic             cout
);
  logic [BLOCK-1:0] p;
  logic             ripple_cout;

  assign p = x ^ y;

  always_comb begin
    logic c;
    c = cin;
    s = '0;
    for (int k = 0; k < BLOCK; k++) begin
      s[k] = p[k] ^ c;
      c    = (x[k] & y[k]) | (p[k] & c);
    end
    ripple_cout = c;
  end

  assign cout = (&p) ? cin : ripple_cout;
endmodule

module carry_skip_sub32_pipe #(
  parameter int WIDTH = 32,
  parameter int BLOCK = 4
) (
  input logic                    clk,
  input logic                    rst,
  carry_skip_sub32_pipe_if.slave bus
);
  localparam int HALF = WIDTH / 2;
  localparam int NB   = HALF / BLOCK;

  logic            s1_valid_reg;
  logic            s2_valid_reg;
  logic [HALF-1:0] diff_lo_reg;
  logic            c_mid_reg;
  logic [HALF-1:0] a_hi_reg;
  logic [HALF-1:0] b_hi_reg;
  logic [WIDTH-1:0] diff_reg;
  logic            borrow_reg;
  logic            ovf_reg;
  logic            zero_reg;

  logic s2_adv, s1_adv, in_ready, accept;

  assign s2_adv   = ~s2_valid_reg | bus.out_ready;
  assign s1_adv   = s1_valid_reg & s2_adv;
  assign in_ready = ~s1_valid_reg | s2_adv;
  assign accept   = bus.in_valid & in_ready;

  // Low half from the live operands, seeded with the inverted borrow-in.
  logic [HALF-1:0] d_lo;
  logic            c_lo [NB+1];
  assign c_lo[0] = ~bus.bin;

  // High half from the stage-1 registers, seeded with the registered mid carry.
  logic [HALF-1:0] d_hi;
  logic            c_hi [NB+1];
  assign c_hi[0] = c_mid_reg;

  genvar gi;
  generate
    for (gi = 0; gi < NB; gi++) begin : g_lo
      carry_skip_sub32_pipe_blk #(.BLOCK(BLOCK)) u_blk (
        .x    (bus.a[gi*BLOCK +: BLOCK]),
        .y    (~bus.b[gi*BLOCK +: BLOCK]),
        .cin  (c_lo[gi]),
        .s    (d_lo[gi*BLOCK +: BLOCK]),
        .cout (c_lo[gi+1])
      );
    end
    for (gi = 0; gi < NB; gi++) begin : g_hi
      carry_skip_sub32_pipe_blk #(.BLOCK(BLOCK)) u_blk (
        .x    (a_hi_reg[gi*BLOCK +: BLOCK]),
        .y    (~b_hi_reg[gi*BLOCK +: BLOCK]),
        .cin  (c_hi[gi]),
        .s    (d_hi[gi*BLOCK +: BLOCK]),
        .cout (c_hi[gi+1])
      );
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_reg <= 1'b0;
      s2_valid_reg <= 1'b0;
      diff_reg     <= '0;
      borrow_reg   <= 1'b0;
      ovf_reg      <= 1'b0;
      zero_reg     <= 1'b0;
    end else begin
      s1_valid_reg <= accept | (s1_valid_reg & ~s2_adv);
      s2_valid_reg <= s1_adv | (s2_valid_reg & ~bus.out_ready);
      if (accept) begin
        diff_lo_reg <= d_lo;
        c_mid_reg   <= c_lo[NB];
        a_hi_reg    <= bus.a[WIDTH-1:HALF];
        b_hi_reg    <= bus.b[WIDTH-1:HALF];
      end
      if (s1_adv) begin
        diff_reg   <= {d_hi, diff_lo_reg};
        borrow_reg <= ~c_hi[NB];
        ovf_reg    <= (a_hi_reg[HALF-1] != b_hi_reg[HALF-1]) && (d_hi[HALF-1] != a_hi_reg[HALF-1]);
        zero_reg   <= ~|diff_lo_reg & ~|d_hi;
      end
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = s2_valid_reg;
  assign bus.diff      = diff_reg;
  assign bus.borrow    = borrow_reg;
  assign bus.ovf       = ovf_reg;
  assign bus.zero      = zero_reg;
endmodule

// File: tb/tb_carry_skip_sub32_pipe.sv
// Scoreboard bench for carry_skip_sub32_pipe: a driver feeds operand sets and queues
// expected results, a monitor pops and compares each result the consumer takes.
module tb_carry_skip_sub32_pipe;
  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        bin;
    logic [31:0] d;
    logic        br;
    logic        ov;
    logic        z;
  } item_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  carry_skip_sub32_pipe_if #(.WIDTH(32)) bus ();

  carry_skip_sub32_pipe #(.WIDTH(32), .BLOCK(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  item_t pend[$];
  item_t sb[$];
  int tests = 0;
  int fails = 0;
  int accepted = 0;
  int popped = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic item_t mk(input logic [31:0] a, input logic [31:0] b, input logic bin,
                               input logic [31:0] d, input logic br, input logic ov, input logic z);
    item_t it;
    it.a = a; it.b = b; it.bin = bin; it.d = d; it.br = br; it.ov = ov; it.z = z;
    return it;
  endfunction

  // Behavioural reference for the random run: plain wide addition, no block structure.
  function automatic item_t ref_item(input logic [31:0] a, input logic [31:0] b, input logic bin);
    logic [32:0] r;
    item_t it;
    r = {1'b0, a} + {1'b0, ~b} + {32'd0, ~bin};
    it.a = a; it.b = b; it.bin = bin;
    it.d  = r[31:0];
    it.br = ~r[32];
    it.ov = (a[31] != b[31]) && (r[31] != a[31]);
    it.z  = (r[31:0] == 32'd0);
    return it;
  endfunction

  // Driver: samples acceptance on the falling edge, presents the next set after the rising edge.
  initial begin
    bus.in_valid = 1'b0;
    bus.a = '0; bus.b = '0; bus.bin = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst && bus.in_valid && bus.in_ready && pend.size() > 0) begin
        sb.push_back(pend.pop_front());
        accepted++;
      end
      @(posedge clk);
      #1;
      if (pend.size() > 0) begin
        bus.a = pend[0].a; bus.b = pend[0].b; bus.bin = pend[0].bin;
        bus.in_valid = 1'b1;
      end else begin
        bus.in_valid = 1'b0;
      end
    end
  end

  // Monitor: one comparison per result handed to the consumer.
  initial begin
    item_t e;
    forever begin
      @(negedge clk);
      if (!rst && bus.out_valid && bus.out_ready) begin
        if (sb.size() == 0) begin
          tests++; fails++;
          $display("[TB] FAIL unexpected_result: got diff=%08h expected no output", bus.diff);
        end else begin
          e = sb.pop_front();
          popped++;
          $display("[TB] result %0d: %08h - %08h - %0d -> diff=%08h b=%0d o=%0d z=%0d",
                   popped, e.a, e.b, e.bin, bus.diff, bus.borrow, bus.ovf, bus.zero);
          chk("result", {29'd0, bus.diff, bus.borrow, bus.ovf, bus.zero},
                        {29'd0, e.d, e.br, e.ov, e.z});
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while ((sb.size() > 0 || pend.size() > 0) && n < budget) begin
      step();
      n++;
    end
    if (sb.size() > 0 || pend.size() > 0) begin
      tests++; fails++;
      $display("[TB] FAIL drain_timeout: got %0d outstanding expected 0", sb.size() + pend.size());
    end
  endtask

  // Issues one op into an empty pipe and checks out_valid rises after the second edge.
  task automatic latency_op(input item_t it, input string name);
    pend.push_back(it);
    step();                       // driver presents operands
    step();                       // accept edge
    chk({name, "_ov_after_1"}, {63'd0, bus.out_valid}, 64'd0);
    step();
    chk({name, "_ov_after_2"}, {63'd0, bus.out_valid}, 64'd1);
    drain(20);
  endtask

  initial begin
    logic [31:0] held;
    int acc0, pop0;
    bus.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b0;
    chk("reset_out_valid", {63'd0, bus.out_valid}, 64'd0);
    chk("reset_in_ready", {63'd0, bus.in_ready}, 64'd1);
    chk("reset_outputs", {29'd0, bus.diff, bus.borrow, bus.ovf, bus.zero}, 64'd0);

    // Directed vectors with hand-computed results.
    latency_op(mk(32'h5, 32'h3, 1'b0, 32'h2, 1'b0, 1'b0, 1'b0), "t1");
    pend.push_back(mk(32'h0, 32'h1, 1'b0, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b0));
    pend.push_back(mk(32'h80000000, 32'h1, 1'b0, 32'h7FFFFFFF, 1'b0, 1'b1, 1'b0));
    pend.push_back(mk(32'h7FFFFFFF, 32'hFFFFFFFF, 1'b0, 32'h80000000, 1'b1, 1'b1, 1'b0));
    pend.push_back(mk(32'h12345678, 32'h12345678, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1));
    pend.push_back(mk(32'h12345678, 32'h12345678, 1'b1, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b0));
    drain(50);

    // Backpressure: consumer stalls for 6 cycles with 4 sets waiting.
    acc0 = accepted; pop0 = popped;
    bus.out_ready = 1'b0;
    pend.push_back(mk(32'h100, 32'h1, 1'b0, 32'hFF, 1'b0, 1'b0, 1'b0));
    pend.push_back(mk(32'h20, 32'h20, 1'b1, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b0));
    pend.push_back(mk(32'hFFFFFFFF, 32'h1, 1'b0, 32'hFFFFFFFE, 1'b0, 1'b0, 1'b0));
    pend.push_back(mk(32'h1, 32'h80000000, 1'b0, 32'h80000001, 1'b1, 1'b1, 1'b0));
    repeat (4) step();
    held = bus.diff;
    chk("stall_out_valid", {63'd0, bus.out_valid}, 64'd1);
    chk("stall_first_diff", {32'd0, held}, {32'd0, 32'hFF});
    repeat (2) step();
    chk("stall_accepted", 64'(accepted - acc0), 64'd2);
    chk("stall_in_ready", {63'd0, bus.in_ready}, 64'd0);
    chk("stall_diff_held", {32'd0, bus.diff}, {32'd0, held});
    bus.out_ready = 1'b1;
    drain(50);
    chk("stall_results_out", 64'(popped - pop0), 64'd4);

    // Reset with both stages full discards the in-flight work.
    bus.out_ready = 1'b0;
    pend.push_back(mk(32'hAAAA, 32'h1111, 1'b0, 32'h9999, 1'b0, 1'b0, 1'b0));
    pend.push_back(mk(32'hBBBB, 32'h1111, 1'b0, 32'hAAAA, 1'b0, 1'b0, 1'b0));
    repeat (5) step();
    chk("full_in_ready", {63'd0, bus.in_ready}, 64'd0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    sb.delete();
    bus.out_ready = 1'b1;
    chk("rst_mid_out_valid", {63'd0, bus.out_valid}, 64'd0);
    chk("rst_mid_in_ready", {63'd0, bus.in_ready}, 64'd1);
    chk("rst_mid_diff", {32'd0, bus.diff}, 64'd0);
    latency_op(mk(32'h10, 32'h1, 1'b0, 32'hF, 1'b0, 1'b0, 1'b0), "t6");

    // Random back-to-back traffic with a randomly stalling consumer.
    for (int i = 0; i < 10000; i++) begin
      logic [31:0] ra, rb;
      ra = $urandom;
      rb = (i % 16 == 0) ? ra : $urandom;
      pend.push_back(ref_item(ra, rb, 1'($urandom_range(0, 1))));
    end
    begin
      int n = 0;
      while ((sb.size() > 0 || pend.size() > 0) && n < 60000) begin
        bus.out_ready = ($urandom_range(0, 3) != 0);
        step();
        n++;
      end
    end
    bus.out_ready = 1'b1;
    drain(20);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
